// File: rtl/timer_pkg.sv
// Shared constants for the APB timer: default widths, clock-select encoding
// and TCR/TSR bit positions used by the register block and the counting core.
package timer_pkg;

    localparam int unsigned CNT_W_DEFAULT = 8;
    localparam int unsigned DIV_W_DEFAULT = 4;

    typedef enum logic [1:0] {
        CKS_DIV2  = 2'b00,
        CKS_DIV4  = 2'b01,
        CKS_DIV8  = 2'b10,
        CKS_DIV16 = 2'b11
    } cks_e;

    localparam int unsigned TSR_OVF = 0;
    localparam int unsigned TSR_UDF = 1;

    localparam int unsigned TCR_LOAD   = 7;
    localparam int unsigned TCR_DN     = 5;
    localparam int unsigned TCR_EN     = 4;
    localparam int unsigned TCR_CKS_HI = 1;
    localparam int unsigned TCR_CKS_LO = 0;

endpackage

// File: rtl/timer_prescaler.sv
// Free-running clock prescaler; produces a registered one-cycle tick whenever
// the low (cks+1) bits of the divider are all ones.
module timer_prescaler
    import timer_pkg::*;
#(
    parameter int unsigned DIV_W = DIV_W_DEFAULT
) (
    input  logic       pclk,
    input  logic       preset,
    input  logic [1:0] cks,
    output logic       tick
);

    logic [DIV_W-1:0] div_cnt;
    logic [DIV_W-1:0] mask;
    logic             tick_c;

    always_comb begin
        mask = '0;
        for (int unsigned i = 0; i < DIV_W; i++) begin
            if (i <= 32'(cks)) begin
                mask[i] = 1'b1;
            end
        end
        tick_c = ((div_cnt & mask) == mask);
    end

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            div_cnt <= '0;
            tick    <= 1'b0;
        end else begin
            div_cnt <= div_cnt + DIV_W'(1);
            tick    <= tick_c;
        end
    end

endmodule

// File: rtl/timer_count_core.sv
// Counting datapath of the APB timer: up/down counter with parallel load,
// sticky overflow/underflow flags cleared by write-1-to-clear strobes.
module timer_count_core
    import timer_pkg::*;
#(
    parameter int unsigned CNT_W = CNT_W_DEFAULT,
    parameter int unsigned DIV_W = DIV_W_DEFAULT
) (
    input  logic             pclk,
    input  logic             preset,
    input  logic [CNT_W-1:0] tdr,
    input  logic             load,
    input  logic             en,
    input  logic             dn,
    input  logic [1:0]       cks,
    input  logic [1:0]       sts_clr,
    output logic [CNT_W-1:0] tcnt,
    output logic [1:0]       tsr,
    output logic             tick
);

    logic [CNT_W-1:0] tcnt_nx;
    logic [1:0]       tsr_nx;
    logic [1:0]       tsr_set;

    timer_prescaler #(
        .DIV_W (DIV_W)
    ) u_prescaler (
        .pclk   (pclk),
        .preset (preset),
        .cks    (cks),
        .tick   (tick)
    );

    // A load discards any coincident tick, so no wrap event can fire with it.
    always_comb begin
        tcnt_nx = tcnt;
        tsr_set = '0;
        if (load) begin
            tcnt_nx = tdr;
        end else if (en && tick) begin
            if (!dn) begin
                tcnt_nx          = tcnt + CNT_W'(1);
                tsr_set[TSR_OVF] = (tcnt == '1);
            end else begin
                tcnt_nx          = tcnt - CNT_W'(1);
                tsr_set[TSR_UDF] = (tcnt == '0);
            end
        end
        tsr_nx = tsr_set | (tsr & ~sts_clr);
    end

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            tcnt <= '0;
            tsr  <= '0;
        end else begin
            tcnt <= tcnt_nx;
            tsr  <= tsr_nx;
        end
    end

endmodule

// File: tb/tb_timer_count_core.sv
// Directed self-checking bench for timer_count_core.
module tb_timer_count_core;

    logic       pclk = 1'b0;
    logic       preset;
    logic [7:0] tdr;
    logic       load;
    logic       en;
    logic       dn;
    logic [1:0] cks;
    logic [1:0] sts_clr;
    logic [7:0] tcnt;
    logic [1:0] tsr;
    logic       tick;

    int checks = 0;
    int errors = 0;

    timer_count_core #(
        .CNT_W (8),
        .DIV_W (4)
    ) dut (
        .pclk    (pclk),
        .preset  (preset),
        .tdr     (tdr),
        .load    (load),
        .en      (en),
        .dn      (dn),
        .cks     (cks),
        .sts_clr (sts_clr),
        .tcnt    (tcnt),
        .tsr     (tsr),
        .tick    (tick)
    );

    always #5 pclk = ~pclk;

    task automatic step();
        @(posedge pclk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_tick(output int n);
        n = 0;
        while (tick !== 1'b1 && n < 40) begin
            step();
            n++;
        end
        chk("tick_timeout", {31'd0, tick}, 32'd1);
    endtask

    task automatic tick_period(input logic [1:0] k, input int expn);
        int n;
        cks = k;
        wait_tick(n);
        step();
        wait_tick(n);
        chk("tick_period", n + 1, expn);
    endtask

    initial begin
        int n;
        preset  = 1'b1;
        tdr     = 8'h00;
        load    = 1'b0;
        en      = 1'b0;
        dn      = 1'b0;
        cks     = 2'b00;
        sts_clr = 2'b00;

        // Reset values, before and across a clock edge
        #2;
        chk("rst_tcnt", {24'd0, tcnt}, 32'h00);
        chk("rst_tsr",  {30'd0, tsr},  32'h0);
        chk("rst_tick", {31'd0, tick}, 32'h0);
        step();
        chk("rst_hold_tcnt", {24'd0, tcnt}, 32'h00);
        preset = 1'b0;

        // 1. Idle with en=0; /2 tick on every even edge after reset release
        for (int i = 1; i <= 100; i++) begin
            step();
            chk("idle_tick", {31'd0, tick}, {31'd0, (i % 2) == 0});
        end
        chk("idle_tcnt", {24'd0, tcnt}, 32'h00);
        chk("idle_tsr",  {30'd0, tsr},  32'h0);

        tick_period(2'b01, 4);
        tick_period(2'b10, 8);
        tick_period(2'b11, 16);
        chk("freeze_tcnt", {24'd0, tcnt}, 32'h00);
        cks = 2'b00;

        // 2. Load FD, count up across the overflow wrap
        tdr = 8'hFD; load = 1'b1;
        step();
        load = 1'b0;
        chk("load_fd", {24'd0, tcnt}, 32'hFD);
        en = 1'b1; dn = 1'b0;
        wait_tick(n); step();
        chk("up_fe", {24'd0, tcnt}, 32'hFE);
        wait_tick(n); step();
        chk("up_ff", {24'd0, tcnt}, 32'hFF);
        chk("up_ff_tsr", {30'd0, tsr}, 32'h0);
        wait_tick(n); step();
        en = 1'b0;
        chk("up_wrap", {24'd0, tcnt}, 32'h00);
        chk("ovf_set", {30'd0, tsr}, 32'h1);

        // 3. Down count from 0 with /16 -> underflow
        dn = 1'b1; cks = 2'b11; en = 1'b1;
        wait_tick(n);
        chk("udf_latency", {31'd0, n <= 16}, 32'd1);
        step();
        en = 1'b0;
        chk("dn_wrap", {24'd0, tcnt}, 32'hFF);
        chk("udf_set", {30'd0, tsr}, 32'h3);

        // 4a. Partial clear, then a write of zero changes nothing
        sts_clr = 2'b01;
        step();
        sts_clr = 2'b00;
        chk("clr_ovf_only", {30'd0, tsr}, 32'h2);
        step();
        chk("clr_zero", {30'd0, tsr}, 32'h2);
        chk("en0_hold", {24'd0, tcnt}, 32'hFF);

        // 5. Overflow and clear of the same bit in one cycle: set wins
        tdr = 8'hFF; load = 1'b1;
        step();
        load = 1'b0; dn = 1'b0; cks = 2'b00; en = 1'b1;
        wait_tick(n);
        sts_clr = 2'b01;
        step();
        sts_clr = 2'b00; en = 1'b0;
        chk("setwin_tcnt", {24'd0, tcnt}, 32'h00);
        chk("setwin_tsr",  {30'd0, tsr},  32'h3);

        // 4b. Clear both bits
        sts_clr = 2'b11;
        step();
        sts_clr = 2'b00;
        chk("clr_both", {30'd0, tsr}, 32'h0);

        // 6. Load coincident with a wrap tick: load wins, no flag
        tdr = 8'hFF; load = 1'b1;
        step();
        load = 1'b0; en = 1'b1;
        wait_tick(n);
        tdr = 8'h10; load = 1'b1;
        step();
        load = 1'b0; en = 1'b0;
        chk("load_prio_tcnt", {24'd0, tcnt}, 32'h10);
        chk("load_prio_tsr",  {30'd0, tsr},  32'h0);

        // Reset asserted mid-count, between clock edges
        tdr = 8'hFE; load = 1'b1;
        step();
        load = 1'b0; en = 1'b1;
        wait_tick(n); step();
        wait_tick(n); step();
        wait_tick(n); step();
        chk("pre_rst_tcnt", {24'd0, tcnt}, 32'h01);
        chk("pre_rst_tsr",  {30'd0, tsr},  32'h1);
        #2;
        preset = 1'b1;
        #1;
        chk("async_rst_tcnt", {24'd0, tcnt}, 32'h00);
        chk("async_rst_tsr",  {30'd0, tsr},  32'h0);
        chk("async_rst_tick", {31'd0, tick}, 32'h0);
        en = 1'b0;
        step();
        chk("rst_held_tcnt", {24'd0, tcnt}, 32'h00);
        preset = 1'b0;
        step();
        chk("post_rst_tick0", {31'd0, tick}, 32'h0);
        step();
        chk("post_rst_tick1", {31'd0, tick}, 32'h1);
        chk("post_rst_tcnt",  {24'd0, tcnt}, 32'h00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
